// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer and its multiplier.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } mac_state_t;

    localparam logic [7:0] FP8_ONE  = 8'h38;
    localparam logic [7:0] INT8_MAX = 8'h7F;
    localparam logic [7:0] INT8_MIN = 8'h80;

endpackage

// File: rtl/signed_multiplier.sv
// Combinational fused multiply-add: result = weight * value + cumulative.
// Int mode saturates to int8; FP8 mode (E4M3, bias 7, every encoding finite)
// computes the exact sum in fixed point, rounds to nearest-even once and
// saturates to the largest magnitude encoding.
module signed_multiplier
    import mac_pkg::*;
(
    input  logic       float_mode,
    input  logic [7:0] weight,
    input  logic [7:0] value,
    input  logic [7:0] cumulative,
    output logic [7:0] result,
    output logic       overflow
);

    // Exact FP8 sums span 2^-18 .. ~2^19; 38 bits holds them without loss.
    localparam int unsigned SUM_W = 38;

    logic signed [15:0] int_prod;
    logic        [16:0] int_sum;
    logic        [7:0]  int_res;
    logic               int_ovf;

    // Int8 multiply-accumulate with saturation.
    always_comb begin
        int_prod = $signed(weight) * $signed(value);
        int_sum  = {int_prod[15], int_prod} + {{9{cumulative[7]}}, cumulative};
        int_res  = int_sum[7:0];
        int_ovf  = 1'b0;
        if (int_sum[16:7] != {10{int_sum[16]}}) begin
            int_ovf = 1'b1;
            int_res = int_sum[16] ? INT8_MIN : INT8_MAX;
        end
    end

    logic [3:0]       sig_w, sig_v, sig_c;
    logic [3:0]       ew, ev, ec;
    logic [4:0]       prod_sh;
    logic [SUM_W-1:0] prod_mag, cum_mag, mag;
    logic             prod_sign, res_sign;
    logic [5:0]       lead, shift_amt, exp_n;
    logic [3:0]       q;
    logic             guard, sticky, rnd;
    logic [4:0]       qr;
    logic [2:0]       mant;
    logic [7:0]       fp_res;
    logic             fp_ovf;

    // FP8 fused multiply-add: align both terms in units of 2^-18, add, round once.
    always_comb begin
        sig_w = {weight[6:3] != 4'd0, weight[2:0]};
        sig_v = {value[6:3] != 4'd0, value[2:0]};
        sig_c = {cumulative[6:3] != 4'd0, cumulative[2:0]};
        ew    = (weight[6:3] == 4'd0) ? 4'd1 : weight[6:3];
        ev    = (value[6:3] == 4'd0) ? 4'd1 : value[6:3];
        ec    = (cumulative[6:3] == 4'd0) ? 4'd1 : cumulative[6:3];

        prod_sh   = 5'(ew) + 5'(ev) - 5'd2;
        prod_mag  = (SUM_W'(sig_w) * SUM_W'(sig_v)) << prod_sh;
        cum_mag   = SUM_W'(sig_c) << (6'(ec) + 6'd8);
        prod_sign = weight[7] ^ value[7];

        if (prod_sign == cumulative[7]) begin
            mag      = prod_mag + cum_mag;
            res_sign = prod_sign;
        end else if (prod_mag >= cum_mag) begin
            mag      = prod_mag - cum_mag;
            res_sign = prod_sign;
        end else begin
            mag      = cum_mag - prod_mag;
            res_sign = cumulative[7];
        end
        if (mag == '0) begin
            res_sign = 1'b0;
        end

        lead = 6'd0;
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                lead = 6'(i);
            end
        end

        // Leading bit >= 12 is a normal number; below that the subnormal grid is 2^-9.
        shift_amt = (lead >= 6'd12) ? (lead - 6'd3) : 6'd9;
        q         = 4'(mag >> shift_amt);
        guard     = mag[shift_amt - 6'd1];
        sticky    = |(mag & ((SUM_W'(1) << (shift_amt - 6'd1)) - SUM_W'(1)));
        rnd       = guard & (sticky | q[0]);
        qr        = 5'(q) + 5'(rnd);

        exp_n = (lead >= 6'd12) ? (lead - 6'd11) : {5'd0, qr[3]};
        mant  = qr[2:0];
        if (qr[4]) begin
            exp_n = exp_n + 6'd1;
            mant  = 3'd0;
        end

        fp_ovf = 1'b0;
        fp_res = {res_sign, exp_n[3:0], mant};
        if (exp_n > 6'd15) begin
            fp_ovf = 1'b1;
            fp_res = {res_sign, 7'h7F};
        end
    end

    // Mode select.
    always_comb begin
        result   = float_mode ? fp_res : int_res;
        overflow = float_mode ? fp_ovf : int_ovf;
    end

endmodule

// File: rtl/mac_sequencer.sv
// Streams weight/value pairs through one signed_multiplier, feeding each
// output back as the next cumulative, and reports the final sum with done.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             float_mode,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       bias,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_weight,
    input  logic [7:0]       in_value,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             result_overflow
);

    mac_state_t       state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             fmode_q, fmode_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       result_q, result_d;
    logic             result_ovf_q, result_ovf_d;

    logic [LEN_W-1:0] len_clamp_c;
    logic [7:0]       mul_out;
    logic             mul_overflow;

    signed_multiplier u_mul (
        .float_mode (fmode_q),
        .weight     (in_weight),
        .value      (in_value),
        .cumulative (acc_q),
        .result     (mul_out),
        .overflow   (mul_overflow)
    );

    // Requested length limited to MAX_LEN.
    always_comb begin
        len_clamp_c = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        fmode_d      = fmode_q;
        ovf_d        = ovf_q;
        result_d     = result_q;
        result_ovf_d = result_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    fmode_d = float_mode;
                    ovf_d   = 1'b0;
                    cnt_d   = len_clamp_c;
                    state_d = (len_clamp_c == '0) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d = mul_out;
                    ovf_d = ovf_q | mul_overflow;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result is captured on entry to FINISH so it is valid alongside done.
        if (state_d == FINISH) begin
            result_d     = acc_d;
            result_ovf_d = ovf_d;
        end

        in_ready_d = (state_d == ACCUM);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            fmode_q      <= 1'b0;
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            fmode_q      <= fmode_d;
            ovf_q        <= ovf_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            result_ovf_q <= result_ovf_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign result          = result_q;
    assign result_overflow = result_ovf_q;

endmodule
